// File: rtl/ls_mem_ctrl.sv
// ls_mem_ctrl: data-memory controller behind the load/store unit.
// Latches one access, runs a valid/ready bus with wait states and returns
// extended load data; flags bus timeouts.
// Ports: req_* (LSU request, req_ready), bus_* (data bus), wb_* (load
// writeback pulse), fault/fault_cause, busy (= !req_ready).
// Param TIMEOUT_CYCLES: REQ+WAIT_R cycle limit, 0 disables the timeout.
// Macro MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of
// forcing the low address bits to size alignment.
module ls_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [4:0]  req_rd,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
`ifdef MISALIGN_TRAP_EN
  localparam logic [2:0] S_MIS  = 3'd4;
`endif

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;

  logic [1:0]  in_size;
  logic [31:0] in_addr;
  logic        tmo_hit;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
`ifdef MISALIGN_TRAP_EN
  logic        mis;
`endif

  // Reserved size 3 is folded into word here so size_q is never 3.
  assign in_size = (req_size == 2'd3) ? 2'd2 : req_size;

`ifdef MISALIGN_TRAP_EN
  assign in_addr = req_addr;
  assign mis = ((in_size == 2'd1) && req_addr[0]) ||
               ((in_size == 2'd2) && (req_addr[1:0] != 2'b00));
`else
  always_comb begin
    in_addr = req_addr;
    case (in_size)
      2'd1:    in_addr = {req_addr[31:1], 1'b0};
      2'd2:    in_addr = {req_addr[31:2], 2'b00};
      default: in_addr = req_addr;
    endcase
  end
`endif

  // Terminal cycle: the timeout only fires if no handshake arrives on it.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                   (cnt_q == TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    ld_byte = bus_rdata[7:0];
    case (addr_q[1:0])
      2'd0: ld_byte = bus_rdata[7:0];
      2'd1: ld_byte = bus_rdata[15:8];
      2'd2: ld_byte = bus_rdata[23:16];
      2'd3: ld_byte = bus_rdata[31:24];
      default: ld_byte = bus_rdata[7:0];
    endcase
  end

  assign ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    ld_data = bus_rdata;
    case (size_q)
      2'd0: ld_data = uns_q ? {24'b0, ld_byte}
                            : {{24{ld_byte[7]}}, ld_byte};
      2'd1: ld_data = uns_q ? {16'b0, ld_half}
                            : {{16{ld_half[15]}}, ld_half};
      default: ld_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    we_d      = we_q;
    uns_d     = uns_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    fault_d   = 1'b0;
    cause_d   = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = in_addr;
          wdata_d = req_wdata;
          size_d  = in_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          rd_d    = req_rd;
          cnt_d   = 32'd0;
          state_d = S_REQ;
`ifdef MISALIGN_TRAP_EN
          if (mis) begin
            state_d = S_MIS;
            fault_d = 1'b1;
            cause_d = req_we ? 2'd3 : 2'd2;
          end
`endif
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 32'd1;
        if (bus_ready) begin
          state_d = we_q ? S_IDLE : S_WAIT;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          fault_d = 1'b1;
          cause_d = 2'd1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (bus_rvalid) begin
          state_d   = S_RESP;
          wb_data_d = ld_data;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          fault_d = 1'b1;
          cause_d = 2'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      size_q    <= 2'd0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      rd_q      <= 5'd0;
      cnt_q     <= 32'd0;
      wb_data_q <= 32'd0;
      fault_q   <= 1'b0;
      cause_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      we_q      <= we_d;
      uns_q     <= uns_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      fault_q   <= fault_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    bus_wstrb = 4'b0000;
    bus_wdata = wdata_q;
    case (size_q)
      2'd0: begin
        bus_wstrb = 4'b0001 << addr_q[1:0];
        bus_wdata = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        bus_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        bus_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        bus_wstrb = 4'b1111;
        bus_wdata = wdata_q;
      end
    endcase
    if (!we_q) bus_wstrb = 4'b0000;
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = !req_ready;
  assign bus_valid   = (state_q == S_REQ);
  assign bus_we      = we_q;
  assign bus_addr    = {addr_q[31:2], 2'b00};
  assign wb_valid    = (state_q == S_RESP);
  assign wb_rd       = rd_q;
  assign wb_data     = wb_data_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;

endmodule
